regfile_access_ctrl: RTL and testbench

Sequencer and arbiter in front of the 8 x 8-bit register file. It shares the single read/write-mode regfile port between two requesters: port 0 is execute/writeback and port 1 is the load unit. It drives the regfile's read/write select, addresses and byte write data. It splits 16-bit register-pair writes into two byte writes and returns read data through a valid/ready request plus a one-cycle response pulse.

---
 rtl/regfile_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 46 ++++
 rtl/regfile_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the regfile access controller.
// Used by regfile_access_ctrl and rr_arbiter2.
package regfile_ctrl_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned NUM_PORTS  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR0,
        ST_WR1
    } state_t;

    // Second byte of a register pair lands in the next register, wrapping 7 -> 0.
    function automatic int unsigned pair_addr_inc(input int unsigned addr);
        return (addr + 1) % NUM_REGS;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter returning a one-hot grant.
// Round-robin when REGFILE_ARB_RR_EN is defined, otherwise fixed priority (port 0 wins).
module rr_arbiter2
    import regfile_ctrl_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_advance,
    output logic [NUM_PORTS-1:0] o_grant
);

`ifdef REGFILE_ARB_RR_EN
    logic r_ptr;

    // Pointer names the preferred port and moves to the loser after each grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_grant[0];
        end
    end

    always_comb begin
        o_grant = '0;
        if (!r_ptr) begin
            if (i_req[0])      o_grant = 2'b01;
            else if (i_req[1]) o_grant = 2'b10;
        end else begin
            if (i_req[1])      o_grant = 2'b10;
            else if (i_req[0]) o_grant = 2'b01;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst, i_advance};

    always_comb begin
        o_grant = '0;
        if (i_req[0])      o_grant = 2'b01;
        else if (i_req[1]) o_grant = 2'b10;
    end
`endif

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequencer/arbiter sharing the single-mode 8x8 regfile port between two requesters.
// Define REGFILE_ARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS-1:0]             req_pair,
    input  logic [NUM_PORTS*ADDR_W-1:0]      req_addr_a,
    input  logic [NUM_PORTS*ADDR_W-1:0]      req_addr_b,
    input  logic [NUM_PORTS*2*DATA_W-1:0]    req_wdata,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [DATA_W-1:0]                rsp_data_a,
    output logic [DATA_W-1:0]                rsp_data_b,
    output logic                             rf_r_w,
    output logic [ADDR_W-1:0]                rf_rs1_addr,
    output logic [ADDR_W-1:0]                rf_rs2_addr,
    output logic [ADDR_W-1:0]                rf_rd_addr,
    output logic [DATA_W-1:0]                rf_rd_data,
    input  logic [DATA_W-1:0]                rf_rs1_data,
    input  logic [DATA_W-1:0]                rf_rs2_data
);

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_W-1:0]       r_op_a;
    logic [ADDR_W-1:0]       r_op_b;
    logic                    r_op_pair;
    logic                    r_op_id;
    logic [2*DATA_W-1:0]     r_op_wdata;

    logic [ADDR_W-1:0]       r_rs1_hold;
    logic [ADDR_W-1:0]       r_rs2_hold;
    logic [ADDR_W-1:0]       r_rd_hold;
    logic [NUM_PORTS-1:0]    r_rsp_valid;
    logic [DATA_W-1:0]       r_rsp_a;
    logic [DATA_W-1:0]       r_rsp_b;

    logic [NUM_PORTS-1:0]    w_grant;
    logic                    w_accept;
    logic                    w_sel;
    logic                    w_done;
    logic [ADDR_W-1:0]       w_pair_addr;

    rr_arbiter2 u_arb (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_req     (req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    assign w_accept    = |(req_valid & req_ready);
    assign w_sel       = req_ready[1];
    assign w_pair_addr = ADDR_W'(pair_addr_inc(32'(r_op_a)));

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data_a  = r_rsp_a;
    assign rsp_data_b  = r_rsp_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = req_write[w_sel] ? ST_WR0 : ST_RD;
                end
            end
            ST_RD:   w_next = ST_IDLE;
            ST_WR0:  w_next = r_op_pair ? ST_WR1 : ST_IDLE;
            ST_WR1:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Idle address outputs come from hold registers so unused ports keep their last value.
    always_comb begin
        req_ready   = '0;
        rf_r_w      = 1'b1;
        rf_rs1_addr = r_rs1_hold;
        rf_rs2_addr = r_rs2_hold;
        rf_rd_addr  = r_rd_hold;
        rf_rd_data  = '0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!reset) begin
                    req_ready = w_grant;
                end
            end
            ST_RD: begin
                rf_rs1_addr = r_op_a;
                rf_rs2_addr = r_op_b;
                w_done      = 1'b1;
            end
            ST_WR0: begin
                rf_r_w     = 1'b0;
                rf_rd_addr = r_op_a;
                rf_rd_data = r_op_pair ? r_op_wdata[2*DATA_W-1:DATA_W] : r_op_wdata[DATA_W-1:0];
                w_done     = !r_op_pair;
            end
            ST_WR1: begin
                rf_r_w     = 1'b0;
                rf_rd_addr = w_pair_addr;
                rf_rd_data = r_op_wdata[DATA_W-1:0];
                w_done     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_pair   <= 1'b0;
            r_op_id     <= 1'b0;
            r_op_wdata  <= '0;
            r_rs1_hold  <= '0;
            r_rs2_hold  <= '0;
            r_rd_hold   <= '0;
            r_rsp_valid <= '0;
            r_rsp_a     <= '0;
            r_rsp_b     <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_done) begin
                r_rsp_valid[r_op_id] <= 1'b1;
            end
            if (w_accept) begin
                r_op_id    <= w_sel;
                r_op_pair  <= req_pair[w_sel];
                r_op_a     <= w_sel ? req_addr_a[2*ADDR_W-1:ADDR_W] : req_addr_a[ADDR_W-1:0];
                r_op_b     <= w_sel ? req_addr_b[2*ADDR_W-1:ADDR_W] : req_addr_b[ADDR_W-1:0];
                r_op_wdata <= w_sel ? req_wdata[4*DATA_W-1:2*DATA_W] : req_wdata[2*DATA_W-1:0];
            end
            if (r_state == ST_RD) begin
                r_rsp_a    <= rf_rs1_data;
                r_rsp_b    <= rf_rs2_data;
                r_rs1_hold <= r_op_a;
                r_rs2_hold <= r_op_b;
            end
            if (r_state == ST_WR0 || r_state == ST_WR1) begin
                r_rd_hold <= rf_rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench: behavioural regfile plus an op-level register model.
module tb_regfile_access_ctrl;
    import regfile_ctrl_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req_valid, req_ready, req_write, req_pair, rsp_valid;
    logic [2*AW-1:0] req_addr_a, req_addr_b;
    logic [4*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_data_a, rsp_data_b, rf_rd_data, rf_rs1_data, rf_rs2_data;
    logic            rf_r_w;
    logic [AW-1:0]   rf_rs1_addr, rf_rs2_addr, rf_rd_addr;

    logic [DW-1:0]   mem      [8];
    logic [DW-1:0]   ref_regs [8];
    int              n_checks = 0;
    int              n_errors = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_pair    (req_pair),
        .req_addr_a  (req_addr_a),
        .req_addr_b  (req_addr_b),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data_a  (rsp_data_a),
        .rsp_data_b  (rsp_data_b),
        .rf_r_w      (rf_r_w),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data)
    );

    always @(posedge clk) begin
        if (!rf_r_w) mem[rf_rd_addr] <= rf_rd_data;
    end
    assign rf_rs1_data = mem[rf_rs1_addr];
    assign rf_rs2_data = mem[rf_rs2_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input int p, input bit wr, input bit pr,
                         input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [15:0] wd);
        int            waited;
        logic [AW-1:0] a1;
        logic [1:0]    onehot;
        waited = 0;
        onehot = 2'(1 << p);
        a1     = AW'((int'(a) + 1) % 8);
        @(negedge clk);
        req_valid[p] = 1'b1;
        req_write[p] = wr;
        req_pair[p]  = pr;
        req_addr_a[p*AW +: AW] = a;
        req_addr_b[p*AW +: AW] = b;
        req_wdata[p*16 +: 16]  = wd;
        #1;
        while (req_ready[p] !== 1'b1 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        check("accept", 32'(req_ready[p]), 32'd1);
        if (req_ready[p] !== 1'b1) begin
            req_valid[p] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        req_addr_a[p*AW +: AW] = AW'($urandom);
        req_wdata[p*16 +: 16]  = 16'($urandom);
        @(negedge clk);
        check("busy_ready", 32'(req_ready), 32'd0);
        check("early_rsp", 32'(rsp_valid), 32'd0);
        if (!wr) begin
            check("rd_mode", 32'(rf_r_w), 32'd1);
            check("rd_rs1", 32'(rf_rs1_addr), 32'(a));
            check("rd_rs2", 32'(rf_rs2_addr), 32'(b));
            @(negedge clk);
            check("rd_rsp", 32'(rsp_valid), 32'(onehot));
            check("rd_data_a", 32'(rsp_data_a), 32'(ref_regs[a]));
            check("rd_data_b", 32'(rsp_data_b), 32'(ref_regs[b]));
            @(negedge clk);
            check("rsp_pulse", 32'(rsp_valid), 32'd0);
            check("rsp_hold_a", 32'(rsp_data_a), 32'(ref_regs[a]));
        end else begin
            check("wr0_mode", 32'(rf_r_w), 32'd0);
            check("wr0_addr", 32'(rf_rd_addr), 32'(a));
            check("wr0_data", 32'(rf_rd_data), pr ? 32'(wd[15:8]) : 32'(wd[7:0]));
            if (pr) begin
                @(negedge clk);
                check("wr1_mode", 32'(rf_r_w), 32'd0);
                check("wr1_addr", 32'(rf_rd_addr), 32'(a1));
                check("wr1_data", 32'(rf_rd_data), 32'(wd[7:0]));
                check("wr1_rsp", 32'(rsp_valid), 32'd0);
                ref_regs[a]  = wd[15:8];
                ref_regs[a1] = wd[7:0];
            end else begin
                ref_regs[a] = wd[7:0];
            end
            @(negedge clk);
            check("wr_rsp", 32'(rsp_valid), 32'(onehot));
            check("idle_mode", 32'(rf_r_w), 32'd1);
            check("idle_wdata", 32'(rf_rd_data), 32'd0);
            check("rd_hold", 32'(rf_rd_addr), pr ? 32'(a1) : 32'(a));
            check("mem_a", 32'(mem[a]), 32'(ref_regs[a]));
            if (pr) check("mem_a1", 32'(mem[a1]), 32'(ref_regs[a1]));
        end
    endtask

    task automatic arb_test();
        int grants;
        int cyc;
        int pref;
        int exp_port;
        grants = 0;
        cyc    = 0;
        pref   = 0;
        @(negedge clk);
        req_valid  = 2'b11;
        req_write  = 2'b00;
        req_addr_a = {3'd4, 3'd1};
        req_addr_b = {3'd6, 3'd2};
        #1;
        while (grants < 4 && cyc < 30) begin
            if (req_ready != 2'b00) begin
`ifdef REGFILE_ARB_RR_EN
                exp_port = pref;
`else
                exp_port = 0;
`endif
                check("arb_grant", 32'(req_ready), 32'(1 << exp_port));
                pref = (req_ready[1] === 1'b1) ? 0 : 1;
                grants++;
                if (grants == 4) break;
            end
            @(negedge clk); #1;
            cyc++;
        end
        check("arb_count", 32'(grants), 32'd4);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        reset      = 1'b1;
        req_valid  = 2'b11;
        req_write  = '0;
        req_pair   = '0;
        req_addr_a = '0;
        req_addr_b = '0;
        req_wdata  = '0;
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_mode", 32'(rf_r_w), 32'd1);
        check("rst_rs1", 32'(rf_rs1_addr), 32'd0);
        check("rst_rs2", 32'(rf_rs2_addr), 32'd0);
        check("rst_rd", 32'(rf_rd_addr), 32'd0);
        check("rst_wdata", 32'(rf_rd_data), 32'd0);
        check("rst_rsp", 32'(rsp_valid), 32'd0);
        check("rst_data", 32'({rsp_data_a, rsp_data_b}), 32'd0);
        repeat (2) @(negedge clk);
        req_valid = 2'b00;
        reset     = 1'b0;

        for (int i = 0; i < 8; i++) begin
            v = (i == 2) ? 8'h11 : (i == 5) ? 8'hA0 : 8'($urandom);
            do_op(i % 2, 1'b1, 1'b0, AW'(i), 3'd0, {8'($urandom), v});
        end

        do_op(0, 1'b0, 1'b0, 3'd2, 3'd5, 16'h0);
        check("tp_read_a", 32'(rsp_data_a), 32'h11);
        check("tp_read_b", 32'(rsp_data_b), 32'hA0);
        do_op(1, 1'b1, 1'b1, 3'd3, 3'd0, 16'hBEEF);
        check("tp_r3", 32'(mem[3]), 32'hBE);
        check("tp_r4", 32'(mem[4]), 32'hEF);
        do_op(0, 1'b1, 1'b1, 3'd7, 3'd0, 16'h1234);
        check("tp_r7", 32'(mem[7]), 32'h12);
        check("tp_r0_wrap", 32'(mem[0]), 32'h34);
        do_op(0, 1'b1, 1'b0, 3'd6, 3'd0, 16'h00C3);
        check("tp_r6", 32'(mem[6]), 32'hC3);
        check("tp_r7_kept", 32'(mem[7]), 32'h12);

        // Reset during the second byte of a pair write at a=1.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_pair[0]  = 1'b1;
        req_addr_a[AW-1:0] = 3'd1;
        req_wdata[15:0]    = 16'h5A6B;
        #1;
        check("mid_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        ref_regs[1] = 8'h5A;
        reset = 1'b1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        #1;
        check("mid_rst_mode", 32'(rf_r_w), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_rst_ready", 32'(req_ready), 32'd0);
            check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid[1] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("mid_post_rsp", 32'(rsp_valid), 32'd0);
        check("mid_r1", 32'(mem[1]), 32'(ref_regs[1]));
        check("mid_r2_kept", 32'(mem[2]), 32'(ref_regs[2]));
        do_op(1, 1'b0, 1'b0, 3'd2, 3'd1, 16'h0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        arb_test();

        for (int n = 0; n < 40; n++) begin
            do_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom), AW'($urandom), 16'($urandom));
        end

        for (int i = 0; i < 8; i++) begin
            check("final_reg", 32'(mem[i]), 32'(ref_regs[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
